// File: rtl/control_unit_pkg.sv
// Shared constants, state encoding and output decode for the hash control FSM.
// The decode is a pure function of the upcoming state, so every output can be registered.
package control_unit_pkg;

  localparam int RATE_PAIRS = 68;
  localparam int LAST_PAIRS = 4;
  localparam int TRITS      = 5;
  localparam int ROUNDS     = 24;

  typedef enum logic [2:0] {
    RST,
    GATHER,
    PUSH,
    ABSORB,
    KECCAK,
    ANS,
    DONE
  } state_e;

  typedef struct packed {
    logic       ovr_rst;
    logic       halt_n;
    logic       fifo1_en;
    logic       fifo2_en;
    logic       fifo2_stop;
    logic       p3_rst1;
    logic       p3_rst2;
    logic [1:0] p3_count;
    logic       hash_rst1;
    logic       hash_rst2;
    logic       hash_sp;
    logic       hash_ans;
    logic       hash_keccak;
    logic       hash_clk;
    logic       hash_fin;
  } ctl_t;

  function automatic ctl_t ctl_idle();
    ctl_t c;
    c        = '0;
    c.halt_n = 1'b1;
    return c;
  endfunction

  function automatic ctl_t decode(input state_e s, input logic [2:0] trit, input logic blk);
    ctl_t c;
    c = ctl_idle();
    case (s)
      RST: begin
        c.ovr_rst   = 1'b1;
        c.p3_rst1   = 1'b1;
        c.hash_rst1 = 1'b1;
      end
      GATHER: begin
        c.fifo1_en = 1'b1;
        // First trit restarts the packer; later trits carry index trit-1.
        if (trit == 3'd0) c.p3_rst2 = 1'b1;
        else              c.p3_count = 2'(trit - 3'd1);
      end
      PUSH: c.fifo2_en = 1'b1;
      ABSORB: begin
        c.fifo2_stop = 1'b1;
        c.hash_sp    = 1'b1;
        c.hash_clk   = 1'b1;
        c.hash_rst2  = 1'b1;
        c.hash_fin   = blk;
      end
      KECCAK: begin
        c.fifo2_stop  = 1'b1;
        c.hash_keccak = 1'b1;
        c.hash_clk    = 1'b1;
        c.hash_fin    = blk;
      end
      ANS: begin
        c.fifo2_stop = 1'b1;
        c.hash_ans   = 1'b1;
        c.hash_clk   = 1'b1;
        c.hash_fin   = 1'b1;
      end
      DONE: begin
        c.fifo2_stop = 1'b1;
        c.halt_n     = 1'b0;
        c.hash_fin   = 1'b1;
      end
      default: c = ctl_idle();
    endcase
    return c;
  endfunction

endpackage

// File: rtl/control_unit_if.sv
// Control strobes from the FSM to the trit/byte FIFOs, packer and hash datapath.
interface control_unit_if;
  logic       ovr_rst;
  logic       halt_n;
  logic       fifo1_en;
  logic       fifo2_en;
  logic       fifo2_stop;
  logic       p3_rst1;
  logic       p3_rst2;
  logic [1:0] p3_count;
  logic       hash_rst1;
  logic       hash_rst2;
  logic       hash_sp;
  logic       hash_ans;
  logic       hash_keccak;
  logic       hash_clk;
  logic       hash_fin;

  modport master (
    output ovr_rst, halt_n, fifo1_en, fifo2_en, fifo2_stop, p3_rst1, p3_rst2, p3_count,
           hash_rst1, hash_rst2, hash_sp, hash_ans, hash_keccak, hash_clk, hash_fin
  );

  modport slave (
    input ovr_rst, halt_n, fifo1_en, fifo2_en, fifo2_stop, p3_rst1, p3_rst2, p3_count,
          hash_rst1, hash_rst2, hash_sp, hash_ans, hash_keccak, hash_clk, hash_fin
  );
endinterface

// File: rtl/control_unit.sv
// Sequencer for trit gathering, byte pushing and two-block Keccak absorption.
// Outputs are registered decodes of the next state, so each strobe is one clean cycle.
module control_unit
  import control_unit_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  control_unit_if.master ctl
);

  state_e     state_q, state_d;
  logic       run_q;
  logic [2:0] trit_q, trit_d;
  logic [6:0] pair_q, pair_d;
  logic [4:0] round_q, round_d;
  logic       blk_q, blk_d;
  ctl_t       out_q;

  logic [6:0] pair_inc;
  logic [6:0] pair_lim;

  assign pair_inc = pair_q + 7'd1;
  assign pair_lim = blk_q ? 7'(LAST_PAIRS) : 7'(RATE_PAIRS);

  always_comb begin
    state_d = state_q;
    trit_d  = trit_q;
    pair_d  = pair_q;
    round_d = round_q;
    blk_d   = blk_q;
    if (!run_q) begin
      // First edge after reset release enters RST.
      state_d = RST;
      trit_d  = 3'd0;
      pair_d  = 7'd0;
      round_d = 5'd0;
      blk_d   = 1'b0;
    end else begin
      case (state_q)
        RST: begin
          state_d = GATHER;
          trit_d  = 3'd0;
        end
        GATHER: begin
          if (trit_q == 3'(TRITS - 1)) begin
            state_d = PUSH;
            trit_d  = 3'd0;
          end else begin
            trit_d = trit_q + 3'd1;
          end
        end
        PUSH: begin
          if (pair_inc == pair_lim) begin
            state_d = ABSORB;
            pair_d  = 7'd0;
          end else begin
            state_d = GATHER;
            pair_d  = pair_inc;
            trit_d  = 3'd0;
          end
        end
        ABSORB: begin
          state_d = KECCAK;
          round_d = 5'd0;
        end
        KECCAK: begin
          if (round_q == 5'(ROUNDS - 1)) begin
            round_d = 5'd0;
            if (blk_q) begin
              state_d = ANS;
            end else begin
              state_d = GATHER;
              blk_d   = 1'b1;
              trit_d  = 3'd0;
            end
          end else begin
            round_d = round_q + 5'd1;
          end
        end
        ANS:     state_d = DONE;
        DONE:    state_d = DONE;
        default: state_d = RST;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RST;
      run_q   <= 1'b0;
      trit_q  <= 3'd0;
      pair_q  <= 7'd0;
      round_q <= 5'd0;
      blk_q   <= 1'b0;
      out_q   <= ctl_idle();
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
      trit_q  <= trit_d;
      pair_q  <= pair_d;
      round_q <= round_d;
      blk_q   <= blk_d;
      out_q   <= decode(state_d, trit_d, blk_d);
    end
  end

  assign ctl.ovr_rst     = out_q.ovr_rst;
  assign ctl.halt_n      = out_q.halt_n;
  assign ctl.fifo1_en    = out_q.fifo1_en;
  assign ctl.fifo2_en    = out_q.fifo2_en;
  assign ctl.fifo2_stop  = out_q.fifo2_stop;
  assign ctl.p3_rst1     = out_q.p3_rst1;
  assign ctl.p3_rst2     = out_q.p3_rst2;
  assign ctl.p3_count    = out_q.p3_count;
  assign ctl.hash_rst1   = out_q.hash_rst1;
  assign ctl.hash_rst2   = out_q.hash_rst2;
  assign ctl.hash_sp     = out_q.hash_sp;
  assign ctl.hash_ans    = out_q.hash_ans;
  assign ctl.hash_keccak = out_q.hash_keccak;
  assign ctl.hash_clk    = out_q.hash_clk;
  assign ctl.hash_fin    = out_q.hash_fin;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench: compares every output each cycle against the documented timeline.
module tb_control_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  control_unit_if cif();

  control_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ctl   (cif)
  );

  // Bit order: ovr_rst halt_n fifo1_en fifo2_en fifo2_stop p3_rst1 p3_rst2
  // p3_count[1:0] hash_rst1 hash_rst2 hash_sp hash_ans hash_keccak hash_clk hash_fin
  localparam logic [15:0] IDLE = 16'h4000;

  logic [15:0] obs_v;
  assign obs_v = {cif.ovr_rst, cif.halt_n, cif.fifo1_en, cif.fifo2_en, cif.fifo2_stop,
                  cif.p3_rst1, cif.p3_rst2, cif.p3_count, cif.hash_rst1, cif.hash_rst2,
                  cif.hash_sp, cif.hash_ans, cif.hash_keccak, cif.hash_clk, cif.hash_fin};

  int checks = 0;
  int errors = 0;
  int n_f1_a, n_f2_a, n_sp_a, n_kec_a, n_fin_a, n_f2_b, n_ans;

  function automatic logic [15:0] exp_at(input int c);
    logic ovr = 1'b0, halt = 1'b1, f1 = 1'b0, f2 = 1'b0, stop = 1'b0, r1 = 1'b0, r2 = 1'b0;
    logic [1:0] cnt = 2'd0;
    logic h1 = 1'b0, h2 = 1'b0, sp = 1'b0, ans = 1'b0, kec = 1'b0, hclk = 1'b0, fin = 1'b0;
    int ph;
    if (c == 0) begin
      ovr = 1'b1; r1 = 1'b1; h1 = 1'b1;
    end else if (c <= 408 || (c >= 434 && c <= 457)) begin
      ph = (c <= 408) ? (c - 1) % 6 : (c - 434) % 6;
      if (ph == 5) f2 = 1'b1;
      else begin
        f1 = 1'b1;
        if (ph == 0) r2 = 1'b1;
        else         cnt = 2'(ph - 1);
      end
    end else if (c == 409 || c == 458) begin
      stop = 1'b1; sp = 1'b1; hclk = 1'b1; h2 = 1'b1; fin = (c == 458);
    end else if (c <= 433 || (c >= 459 && c <= 482)) begin
      stop = 1'b1; kec = 1'b1; hclk = 1'b1; fin = (c >= 459);
    end else if (c == 483) begin
      stop = 1'b1; ans = 1'b1; hclk = 1'b1; fin = 1'b1;
    end else begin
      stop = 1'b1; halt = 1'b0; fin = 1'b1;
    end
    return {ovr, halt, f1, f2, stop, r1, r2, cnt, h1, h2, sp, ans, kec, hclk, fin};
  endfunction

  // hash_fin is left unconstrained while the final block is being gathered.
  function automatic logic [15:0] mask_at(input int c);
    return (c >= 434 && c <= 457) ? 16'hFFFE : 16'hFFFF;
  endfunction

  task automatic run_timeline(input int last);
    logic [15:0] e, m;
    n_f1_a = 0; n_f2_a = 0; n_sp_a = 0; n_kec_a = 0; n_fin_a = 0; n_f2_b = 0; n_ans = 0;
    for (int c = 0; c <= last; c++) begin
      @(negedge clk);
      e = exp_at(c);
      m = mask_at(c);
      checks++;
      assert ((obs_v & m) === (e & m)) else begin
        errors++;
        $error("FAIL cycle%0d outputs observed=%h expected=%h", c, obs_v & m, e & m);
      end
      if (c <= 433) begin
        n_f1_a  += int'(cif.fifo1_en);
        n_f2_a  += int'(cif.fifo2_en);
        n_sp_a  += int'(cif.hash_sp);
        n_kec_a += int'(cif.hash_keccak);
        n_fin_a += int'(cif.hash_fin);
      end else if (c <= 457) begin
        n_f2_b += int'(cif.fifo2_en);
      end
      n_ans += int'(cif.hash_ans);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_vec(input string tag, input logic [15:0] exp);
    checks++;
    assert (obs_v === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs_v, exp);
    end
  endtask

  task automatic check_counts(input int last);
    check_int("fifo1_en_count_blk0", n_f1_a, 340);
    check_int("fifo2_en_count_blk0", n_f2_a, 68);
    check_int("hash_sp_count_blk0", n_sp_a, 1);
    check_int("hash_keccak_count_blk0", n_kec_a, 24);
    check_int("hash_fin_blk0", n_fin_a, 0);
    check_int("fifo2_en_count_blk1", n_f2_b, 4);
    check_int("hash_ans_count", n_ans, (last >= 483) ? 1 : 0);
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_vec("reset_idle", IDLE);

    rst_n = 1'b1;
    run_timeline(495);
    check_counts(495);
    check_int("halt_n_after_done", int'(cif.halt_n), 0);

    // Abort mid-KECCAK of the first block, away from a clock edge.
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_timeline(420);
    #2 rst_n = 1'b0;
    #1 check_vec("async_abort_idle", IDLE);
    @(posedge clk);
    #1 check_vec("abort_held_idle", IDLE);
    @(negedge clk);
    rst_n = 1'b1;
    run_timeline(495);
    check_counts(495);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
